alu_aluout_and_memory_sub1_e_blk: RTL and testbench
===================================================

ALU_ALUOUT_AND_MEMORY_SUB1_E_BLK -- requirements
Module: alu_aluout_and_memory_sub1_e

**Interface**
- REQ-001: Parameter DATA_W SHALL be as follows: default 16; width of data, operands and memory words.
- REQ-002: Parameter ADDR_W SHALL be as follows: default 16; memory address width, depth 2^ADDR_W words.
- REQ-003: Port CLK SHALL be: input, 1 bit; the single clock, all state updates on its rising edge.
- REQ-004: Port reset SHALL be: input, 1 bit; synchronous, active-high reset.
- REQ-005: Port ALUOp SHALL be: input, 2 bits; operation select.
- REQ-006: Port Avalue SHALL be: input, DATA_W bits; ALU operand A.
- REQ-007: Port signImm SHALL be: input, DATA_W bits; ALU operand B (sign-extended immediate).
- REQ-008: Port Bvalue SHALL be: input, DATA_W bits; memory write data.
- REQ-009: Port wea SHALL be: input, 1 bit; memory write enable.
- REQ-010: Port MemOutVal SHALL be: output, DATA_W bits; registered memory read data.
- REQ-011: Port zero_out SHALL be: output, 1 bit; registered flag, set when the ALU result is 0.
- REQ-012: Port ovflw_out SHALL be: output, 1 bit; registered signed-overflow flag.

**Function**
- REQ-013: The ALU SHALL compute the following from Avalue and signImm, modulo 2^DATA_W:
  - ALUOp 00 = A AND B
  - ALUOp 01 = A + B
  - ALUOp 10 = A - B
  - ALUOp 11 = A OR B
- REQ-014: Edge 1: the ALUOut register SHALL capture the ALU result, and zero_out/ovflw_out SHALL capture their flags for the same result.
- REQ-015: Edge 2: the memory SHALL be addressed by the ALUOut bits [ADDR_W-1:0].
  - If wea=1 at that edge, mem[ALUOut] <= Bvalue, using the Bvalue present at that edge.
  - The read register SHALL capture mem[ALUOut] in write-first mode: on a simultaneous write to the same address it returns the new data.
- REQ-016: Edge 3: MemOutVal SHALL capture the read register, giving a total latency of 3 rising edges from input to MemOutVal.
- REQ-017: The pipeline SHALL be fully pipelined, accepting a new input every cycle with no handshake and no stalls.
- REQ-018: ovflw_out SHALL be set only for ADD/SUB signed overflow and SHALL be 0 for AND/OR.
- REQ-019: Addresses SHALL wrap modulo 2^ADDR_W (for example, 0xFFFF + 1 addresses word 0).
- REQ-020: Memory initial contents SHALL be word0=0x00F0, word1=0x10F0, word2=0x00F4, all other words 0x0000.

**Reset**
- REQ-021: While reset=1 at a rising edge, ALUOut, the read register, MemOutVal, zero_out and ovflw_out SHALL all become 0.
- REQ-022: Writes SHALL be suppressed while reset=1.
- REQ-023: Memory contents SHALL NOT be affected by reset.
- REQ-024: An operation in flight when reset is asserted SHALL be discarded, and outputs SHALL stay 0 until fresh inputs have propagated through all 3 edges.

**Configuration**
- REQ-025: With macro ALU_OVFLW_DETECT_EN defined, ovflw_out SHALL behave per REQ-012 and REQ-018.
- REQ-026: Without ALU_OVFLW_DETECT_EN, ovflw_out SHALL be constant 0 and no overflow logic SHALL be synthesized.

**Structure**
- REQ-027: A shared package alu_mem_pkg SHALL hold:
  - the ALUOp encoding constants (ALU_AND, ALU_ADD, ALU_SUB, ALU_OR);
  - the DATA_W/ADDR_W defaults;
  - the memory initial-content constants.
- REQ-028: One sub-module, alu16, SHALL be purely combinational, taking A, B and op and producing the result, zero and overflow.
- REQ-029: The memory SHALL be inferred as single-port block RAM inside the top module.

**Verification**
- REQ-030: Read pipeline: ALUOp=01, imm=0, wea=0, A=0,1,2 on successive cycles -> MemOutVal = 0x00F0, 0x10F0, 0x00F4 on the 3rd, 4th and 5th edges.
- REQ-031: Address via immediate: A=0, imm=1 -> MemOutVal=0x10F0 three edges later.
- REQ-032: Write-first: A=0x1234, imm=0, B=0x8888, wea=1 for the cycle in which ALUOut=0x1234 -> MemOutVal=0x8888 at that op's 3rd edge.
- REQ-033: Readback of the written word, plus retention of the initial contents:
  - A=0x1232, imm=0x0002 -> MemOutVal=0x8888.
  - A=0 -> MemOutVal=0x00F0 (word 0 unchanged).
- REQ-034: Flags with ALU_OVFLW_DETECT_EN defined:
  - ALUOp=01, A=0x7FFF, imm=1 -> ovflw_out=1, zero_out=0.
  - ALUOp=10, A=0x0005, imm=0x0005 -> zero_out=1, ovflw_out=0.
- REQ-035: Reset: assert reset for 1 edge mid-pipeline -> MemOutVal, zero_out and ovflw_out are 0 next cycle, and memory word 0 still reads 0x00F0 afterwards.

Source files
------------

// File: rtl/alu_mem_pkg.sv
// Shared constants for the ALU/memory pipeline: op encodings, default widths, RAM init words.
// Pure declarations; no logic.
package alu_mem_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [15:0] MEM_INIT_W0 = 16'h00F0;
  localparam logic [15:0] MEM_INIT_W1 = 16'h10F0;
  localparam logic [15:0] MEM_INIT_W2 = 16'h00F4;
endpackage

// File: rtl/alu_aluout_and_memory_sub1_e_blk_alu16.sv
// Combinational ALU (AND/ADD/SUB/OR) with zero flag; signed-overflow flag only when
// ALU_OVFLW_DETECT_EN is defined, otherwise tied to 0. Zero latency, no backpressure.
module alu16
  import alu_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovflw
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_OVFLW_DETECT_EN
  // Overflow when the result sign disagrees with what the operand signs allow.
  always_comb begin
    ovflw = 1'b0;
    case (op)
      ALU_ADD: ovflw = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      ALU_SUB: ovflw = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      default: ovflw = 1'b0;
    endcase
  end
`else
  assign ovflw = 1'b0;
`endif

endmodule

// File: rtl/alu_aluout_and_memory_sub1_e_blk.sv
// ALU result addresses a single-port write-first RAM; MemOutVal is 3 edges after the inputs,
// flags 1 edge after. Fully pipelined, no stalls. Optional overflow flag: ALU_OVFLW_DETECT_EN.
module alu_aluout_and_memory_sub1_e_blk
  import alu_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [1:0]        ALUOp,
  input  logic [DATA_W-1:0] Avalue,
  input  logic [DATA_W-1:0] signImm,
  input  logic [DATA_W-1:0] Bvalue,
  input  logic              wea,
  output logic [DATA_W-1:0] MemOutVal,
  output logic              zero_out,
  output logic              ovflw_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_ovflw;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] rd_q;
  logic              op_vld;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH] = '{
    0: DATA_W'(MEM_INIT_W0),
    1: DATA_W'(MEM_INIT_W1),
    2: DATA_W'(MEM_INIT_W2),
    default: '0
  };

  alu16 #(.DATA_W(DATA_W)) u_alu (
    .a      (Avalue),
    .b      (signImm),
    .op     (ALUOp),
    .result (alu_res),
    .zero   (alu_zero),
    .ovflw  (alu_ovflw)
  );

  assign mem_addr = alu_out[ADDR_W-1:0];
  // op_vld marks alu_out as a real operation rather than the reset flush value.
  assign mem_we   = wea && op_vld && !reset;

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= Bvalue;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      alu_out   <= '0;
      zero_out  <= 1'b0;
      ovflw_out <= 1'b0;
      op_vld    <= 1'b0;
      rd_q      <= '0;
      MemOutVal <= '0;
    end else begin
      alu_out   <= alu_res;
      zero_out  <= alu_zero;
      ovflw_out <= alu_ovflw;
      op_vld    <= 1'b1;
      rd_q      <= !op_vld ? '0 : (wea ? Bvalue : mem[mem_addr]);
      MemOutVal <= rd_q;
    end
  end

endmodule

// File: tb/tb_alu_aluout_and_memory_sub1_e_blk.sv
// Directed + randomized bench for the ALU/memory pipeline against a per-operation model.
module tb_alu_aluout_and_memory_sub1_e_blk;
  import alu_mem_pkg::*;

  localparam int NE = 2048;

  logic        CLK = 1'b0;
  logic        reset;
  logic [1:0]  ALUOp;
  logic [15:0] Avalue, signImm, Bvalue;
  logic        wea;
  logic [15:0] MemOutVal;
  logic        zero_out, ovflw_out;

  int tests = 0;
  int fails = 0;
  int e = 0;

  logic        rst_a [NE];
  logic [15:0] res_a [NE];
  logic [15:0] rd_a  [NE];
  logic [15:0] mem_m [int];

  alu_aluout_and_memory_sub1_e_blk dut (
    .CLK(CLK), .reset(reset), .ALUOp(ALUOp), .Avalue(Avalue), .signImm(signImm),
    .Bvalue(Bvalue), .wea(wea), .MemOutVal(MemOutVal), .zero_out(zero_out), .ovflw_out(ovflw_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] m_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int s;
    case (op)
      2'd0: return a & b;
      2'd1: begin s = int'(a) + int'(b); return s[15:0]; end
      2'd2: begin s = int'(a) - int'(b); return s[15:0]; end
      default: return a | b;
    endcase
  endfunction

  function automatic logic m_ovf(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == 2'd1) s = sa + sb;
    else if (op == 2'd2) s = sa - sb;
    else return 1'b0;
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [15:0] m_rd(input int addr);
    if (mem_m.exists(addr)) return mem_m[addr];
    if (addr == 0) return 16'h00F0;
    if (addr == 1) return 16'h10F0;
    if (addr == 2) return 16'h00F4;
    return 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // One clock edge: drive inputs, update the model, compare all outputs.
  task automatic step(input logic r, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] imm, input logic [15:0] b, input logic we);
    logic [15:0] exp_out;
    logic        exp_z, exp_v;
    int          addr;
    reset = r; ALUOp = op; Avalue = a; signImm = imm; Bvalue = b; wea = we;
    @(posedge CLK);
    #1;
    rst_a[e] = r;
    res_a[e] = m_alu(op, a, imm);
    rd_a[e]  = 16'h0;
    if (!r && e >= 1 && !rst_a[e-1]) begin
      addr = int'(res_a[e-1]);
      if (we) begin
        mem_m[addr] = b;
        rd_a[e-1]   = b;
      end else begin
        rd_a[e-1] = m_rd(addr);
      end
    end
    exp_out = (e >= 2 && !r && !rst_a[e-1] && !rst_a[e-2]) ? rd_a[e-2] : 16'h0;
    exp_z   = r ? 1'b0 : (res_a[e] == 16'h0);
`ifdef ALU_OVFLW_DETECT_EN
    exp_v   = r ? 1'b0 : m_ovf(op, a, imm);
`else
    exp_v   = 1'b0;
`endif
    chk("mem_out", MemOutVal, exp_out);
    chk("zero_out", {15'h0, zero_out}, {15'h0, exp_z});
    chk("ovflw_out", {15'h0, ovflw_out}, {15'h0, exp_v});
    e++;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [15:0] ra, ri, rb;
    logic        rr, rw;

    step(1, ALU_ADD, 16'h0, 16'h0, 16'h0, 0);
    step(1, ALU_ADD, 16'h0, 16'h0, 16'h0, 0);
    chk("reset_mem_out", MemOutVal, 16'h0);

    step(0, ALU_ADD, 16'h0000, 16'h0000, 16'h0, 0);
    step(0, ALU_ADD, 16'h0001, 16'h0000, 16'h0, 0);
    step(0, ALU_ADD, 16'h0002, 16'h0000, 16'h0, 0);
    chk("d_read_w0", MemOutVal, 16'h00F0);
    step(0, ALU_ADD, 16'h0000, 16'h0001, 16'h0, 0);
    chk("d_read_w1", MemOutVal, 16'h10F0);
    step(0, ALU_ADD, 16'h1234, 16'h0000, 16'h0, 0);
    chk("d_read_w2", MemOutVal, 16'h00F4);
    step(0, ALU_ADD, 16'h1232, 16'h0002, 16'h8888, 1);
    chk("d_imm_addr", MemOutVal, 16'h10F0);
    step(0, ALU_ADD, 16'h0000, 16'h0000, 16'h0, 0);
    chk("d_write_first", MemOutVal, 16'h8888);
    step(0, ALU_SUB, 16'h0005, 16'h0005, 16'h0, 0);
    chk("d_readback", MemOutVal, 16'h8888);
    chk("d_sub_zero", {15'h0, zero_out}, 16'h1);
    chk("d_sub_novf", {15'h0, ovflw_out}, 16'h0);
    step(0, ALU_ADD, 16'h7FFF, 16'h0001, 16'h0, 0);
    chk("d_w0_kept", MemOutVal, 16'h00F0);
    chk("d_ovf_nz", {15'h0, zero_out}, 16'h0);
`ifdef ALU_OVFLW_DETECT_EN
    chk("d_ovf", {15'h0, ovflw_out}, 16'h1);
`else
    chk("d_ovf_off", {15'h0, ovflw_out}, 16'h0);
`endif
    step(0, ALU_AND, 16'hFFFF, 16'h0000, 16'h0, 0);
    step(1, ALU_ADD, 16'h0001, 16'h0000, 16'h0, 0);
    chk("d_rst_mem_out", MemOutVal, 16'h0);
    chk("d_rst_zero", {15'h0, zero_out}, 16'h0);
    step(0, ALU_ADD, 16'h0000, 16'h0000, 16'h0, 0);
    chk("d_rst_hold1", MemOutVal, 16'h0);
    step(0, ALU_ADD, 16'hFFFF, 16'h0001, 16'h0, 0);
    chk("d_rst_hold2", MemOutVal, 16'h0);
    chk("d_wrap_zero", {15'h0, zero_out}, 16'h1);
    step(0, ALU_OR, 16'h0000, 16'h0002, 16'h0, 0);
    chk("d_post_rst_w0", MemOutVal, 16'h00F0);
    step(0, ALU_OR, 16'h0000, 16'h0000, 16'h0, 0);
    chk("d_wrap_w0", MemOutVal, 16'h00F0);

    for (int i = 0; i < 1500; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      ri  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rb  = 16'($urandom);
      rw  = ($urandom_range(0, 9) < 3);
      rr  = ($urandom_range(0, 99) == 0);
      step(rr, rop, ra, ri, rb, rw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
